lsu_rmw_wb: RTL and testbench

//  Parametrised load/store write-back unit. It is the successor to the combinational write-back stage.

---
 rtl/lsu_rmw_wb_if.sv | 35 +++
 rtl/lsu_rmw_wb.sv | 216 +++++++++++++++++++++
 tb/tb_lsu_rmw_wb.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_rmw_wb_if.sv
// Request channel and word-bus channel of the load/store write-back unit.
// master is the unit itself (accepts ops, masters the bus); slave is the requester plus memory.
interface lsu_rmw_wb_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned REG_AW = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [REG_AW-1:0] req_rd;

    logic              bus_req;
    logic              bus_gnt;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [XLEN-1:0]   bus_wdata;
    logic              bus_rvalid;
    logic [XLEN-1:0]   bus_rdata;

    modport master (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
               bus_gnt, bus_rvalid, bus_rdata,
        output req_ready, bus_req, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
               bus_gnt, bus_rvalid, bus_rdata,
        input  req_ready, bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/lsu_rmw_wb.sv
// Load/store write-back unit: single-outstanding word bus, read-modify-write for sub-word
// stores, optional split of word-crossing accesses, sign/zero-extended load write-back.
module lsu_rmw_wb #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned REG_AW      = 5,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              arst,
    lsu_rmw_wb_if.master      io_lsu,
    output logic              reg_w_ena_o,
    output logic [REG_AW-1:0] reg_w_addr_o,
    output logic [XLEN-1:0]   reg_w_data_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int NB    = int'(XLEN) / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [2:0] {
        StIdle, StRd0, StRd1, StWr0, StWr1, StResp, StErr
    } state_e;

    state_e            r_state, w_state_nxt;
    logic              r_store, r_sext, r_cross, r_pend;
    logic [3:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata, r_w0, r_w1;
    logic [REG_AW-1:0] r_rd;

    logic              w_legal, w_sext, w_cross, w_accept;
    logic [3:0]        w_size;
    logic [4:0]        w_end;
    logic [OFF_W-1:0]  w_off, w_roff;
    logic              w_rd_state, w_rd_hit, w_bus_req, w_wr_fin;
    logic [ADDR_W-1:0] w_base;
    logic [2*NB-1:0]   w_lmask, w_smask2;
    logic [2*XLEN-1:0] w_sdat2;
    logic [XLEN-1:0]   w_merged0, w_merged1, w_lo, w_ldata;
    logic              w_sbit;

    // Decode size / legality / extension of the incoming op.
    always_comb begin
        w_legal = 1'b1;
        w_sext  = 1'b0;
        w_size  = 4'd1;
        if (io_lsu.req_store) begin
            case (io_lsu.req_funct3)
                3'b000:  w_size = 4'd1;
                3'b001:  w_size = 4'd2;
                3'b010:  w_size = 4'd4;
                3'b011: begin
                    w_size  = 4'd8;
                    w_legal = (XLEN == 64);
                end
                default: w_legal = 1'b0;
            endcase
        end else begin
            case (io_lsu.req_funct3)
                3'b000: begin
                    w_size = 4'd1;
                    w_sext = 1'b1;
                end
                3'b001: begin
                    w_size = 4'd2;
                    w_sext = 1'b1;
                end
                3'b010: begin
                    w_size = 4'd4;
                    w_sext = (XLEN == 64);
                end
                3'b011: begin
                    w_size  = 4'd8;
                    w_legal = (XLEN == 64);
                end
                3'b100:  w_size = 4'd1;
                3'b101:  w_size = 4'd2;
                3'b110: begin
                    w_size  = 4'd4;
                    w_legal = (XLEN == 64);
                end
                default: w_legal = 1'b0;
            endcase
        end
    end

    assign w_off    = io_lsu.req_addr[OFF_W-1:0];
    assign w_end    = 5'(w_off) + 5'(w_size);
    assign w_cross  = (w_end > 5'(NB));
    assign w_accept = io_lsu.req_valid && (r_state == StIdle);

    assign w_roff     = r_addr[OFF_W-1:0];
    assign w_base     = r_addr & ~ADDR_W'(NB - 1);
    assign w_rd_state = (r_state == StRd0) || (r_state == StRd1);
    // A read beat only counts when this op has a granted read outstanding.
    assign w_rd_hit   = w_rd_state && r_pend && io_lsu.bus_rvalid;
    assign w_bus_req  = (w_rd_state && !r_pend) || (r_state == StWr0) || (r_state == StWr1);
    assign w_wr_fin   = io_lsu.bus_gnt &&
                        (((r_state == StWr0) && !r_cross) || (r_state == StWr1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (io_lsu.req_valid) begin
                    if (!w_legal || (w_cross && !MISALIGN_EN)) begin
                        w_state_nxt = StErr;
                    end else if (!io_lsu.req_store || (w_size != 4'(NB)) || w_cross) begin
                        w_state_nxt = StRd0;
                    end else begin
                        w_state_nxt = StWr0;
                    end
                end
            end
            StRd0: begin
                if (w_rd_hit) begin
                    w_state_nxt = r_cross ? StRd1 : (r_store ? StWr0 : StResp);
                end
            end
            StRd1: begin
                if (w_rd_hit) w_state_nxt = r_store ? StWr0 : StResp;
            end
            StWr0: begin
                if (io_lsu.bus_gnt) w_state_nxt = r_cross ? StWr1 : StIdle;
            end
            StWr1: begin
                if (io_lsu.bus_gnt) w_state_nxt = StIdle;
            end
            StResp:  w_state_nxt = StIdle;
            StErr:   w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= StIdle;
            r_store <= 1'b0;
            r_sext  <= 1'b0;
            r_cross <= 1'b0;
            r_pend  <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= '0;
            r_w0    <= '0;
            r_w1    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_store <= io_lsu.req_store;
                r_sext  <= w_sext;
                r_cross <= w_cross;
                r_size  <= w_size;
                r_addr  <= io_lsu.req_addr;
                r_wdata <= io_lsu.req_wdata;
                r_rd    <= io_lsu.req_rd;
                r_w0    <= '0;
                r_w1    <= '0;
            end
            if (w_rd_state && w_bus_req && io_lsu.bus_gnt) begin
                r_pend <= 1'b1;
            end else if (w_rd_hit) begin
                r_pend <= 1'b0;
            end
            if (w_rd_hit) begin
                if (r_state == StRd0) r_w0 <= io_lsu.bus_rdata;
                else                  r_w1 <= io_lsu.bus_rdata;
            end
        end
    end

    // Store bytes placed across the two-word window {w1,w0} starting at the byte offset.
    always_comb begin
        w_lmask   = '0;
        w_merged0 = '0;
        w_merged1 = '0;
        for (int b = 0; b < 2 * NB; b++) begin
            w_lmask[b] = (b < int'(r_size));
        end
        w_smask2 = w_lmask << w_roff;
        w_sdat2  = {{XLEN{1'b0}}, r_wdata} << {w_roff, 3'b000};
        for (int b = 0; b < NB; b++) begin
            w_merged0[8*b +: 8] = w_smask2[b]      ? w_sdat2[8*b +: 8]        : r_w0[8*b +: 8];
            w_merged1[8*b +: 8] = w_smask2[NB + b] ? w_sdat2[8*(NB + b) +: 8] : r_w1[8*b +: 8];
        end
    end

    always_comb begin
        w_lo    = XLEN'({r_w1, r_w0} >> {w_roff, 3'b000});
        w_sbit  = 1'b0;
        w_ldata = '0;
        for (int i = 0; i < int'(XLEN); i++) begin
            if (i == 8 * int'(r_size) - 1) w_sbit = w_lo[i];
        end
        for (int i = 0; i < int'(XLEN); i++) begin
            w_ldata[i] = (i < 8 * int'(r_size)) ? w_lo[i] : (r_sext & w_sbit);
        end
    end

    assign io_lsu.req_ready = (r_state == StIdle);
    assign io_lsu.bus_req   = w_bus_req;
    assign io_lsu.bus_we    = (r_state == StWr0) || (r_state == StWr1);
    assign io_lsu.bus_addr  = ((r_state == StRd0) || (r_state == StWr0)) ? w_base :
                              ((r_state == StRd1) || (r_state == StWr1)) ?
                              (w_base + ADDR_W'(NB)) : '0;
    assign io_lsu.bus_wdata = (r_state == StWr0) ? w_merged0 :
                              (r_state == StWr1) ? w_merged1 : '0;

    assign reg_w_ena_o  = (r_state == StResp) && (r_rd != '0);
    assign reg_w_addr_o = reg_w_ena_o ? r_rd : '0;
    assign reg_w_data_o = reg_w_ena_o ? w_ldata : '0;
    assign done_o       = (r_state == StResp) || (r_state == StErr) || w_wr_fin;
    assign err_o        = (r_state == StErr);
endmodule

// File: tb/tb_lsu_rmw_wb.sv
// Scoreboard bench for lsu_rmw_wb: a split-capable instance with a memory responder and a
// no-split instance that must flag crossing accesses without touching the bus.
module tb_lsu_rmw_wb;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned REG_AW = 5;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    lsu_rmw_wb_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .REG_AW(REG_AW)) if_a ();
    lsu_rmw_wb_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .REG_AW(REG_AW)) if_b ();

    logic              a_ena, a_done, a_err, b_ena, b_done, b_err;
    logic [REG_AW-1:0] a_waddr, b_waddr;
    logic [XLEN-1:0]   a_wdata, b_wdata;

    lsu_rmw_wb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .MISALIGN_EN(1'b1)) u_dut_a (
        .clk          (clk),
        .arst         (arst),
        .io_lsu       (if_a),
        .reg_w_ena_o  (a_ena),
        .reg_w_addr_o (a_waddr),
        .reg_w_data_o (a_wdata),
        .done_o       (a_done),
        .err_o        (a_err)
    );

    lsu_rmw_wb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .MISALIGN_EN(1'b0)) u_dut_b (
        .clk          (clk),
        .arst         (arst),
        .io_lsu       (if_b),
        .reg_w_ena_o  (b_ena),
        .reg_w_addr_o (b_waddr),
        .reg_w_data_o (b_wdata),
        .done_o       (b_done),
        .err_o        (b_err)
    );

    // fin: done must coincide with the last expected bus write of the op.
    typedef struct packed {
        logic        fin;
        logic        err;
        logic        ena;
        logic [4:0]  rd;
        logic [31:0] data;
    } resp_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t       exp_resp[$];
    wr_t         exp_wr[$];
    int          exp_b[$];
    int          checks = 0;
    int          failures = 0;
    int          rd_gnts = 0;
    int          b_req_seen = 0;
    int          cyc = 0;
    logic [31:0] mem [0:15];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic resp_t mk(input logic fin, input logic e, input logic en,
                                 input logic [4:0] rd, input logic [31:0] d);
        return {fin, e, en, rd, d};
    endfunction

    function automatic wr_t mkw(input logic [31:0] a, input logic [31:0] d);
        return {a, d};
    endfunction

    // Memory responder for instance A: gnt on the second request cycle, rvalid 3 cycles later.
    initial begin : resp_a
        int          rv_cnt;
        logic        seen;
        logic [31:0] raddr;
        rv_cnt = 0;
        seen   = 1'b0;
        raddr  = '0;
        if_a.bus_gnt    = 1'b0;
        if_a.bus_rvalid = 1'b0;
        if_a.bus_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if_a.bus_gnt    = 1'b0;
            if_a.bus_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    if_a.bus_rvalid = 1'b1;
                    if_a.bus_rdata  = mem[raddr[5:2]];
                end
            end else if (if_a.bus_req) begin
                if (!seen) begin
                    seen = 1'b1;
                end else begin
                    seen = 1'b0;
                    if_a.bus_gnt = 1'b1;
                    if (if_a.bus_we) begin
                        mem[if_a.bus_addr[5:2]] = if_a.bus_wdata;
                    end else begin
                        raddr  = if_a.bus_addr;
                        rv_cnt = 3;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : mon_a
        wr_t   ew;
        resp_t er;
        logic  last;
        last = 1'b0;
        if (!arst) begin
            if (if_a.bus_req && if_a.bus_gnt) begin
                if (!if_a.bus_we) begin
                    rd_gnts++;
                end else if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bus_write_unexpected actual=0x%0h/0x%0h required=none",
                             if_a.bus_addr, if_a.bus_wdata);
                end else begin
                    ew = exp_wr.pop_front();
                    check("bus_write", {if_a.bus_addr, if_a.bus_wdata}, ew);
                    last = (exp_wr.size() == 0);
                end
            end
            if (a_done) begin
                if (exp_resp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected actual=1 required=0");
                end else begin
                    er = exp_resp.pop_front();
                    check("response", {last, a_err, a_ena, a_waddr, a_wdata}, er);
                    if (!a_ena) check("reg_zero_when_off", {a_waddr, a_wdata}, 64'h0);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        int e;
        if (!arst) begin
            if (if_b.bus_req) b_req_seen++;
            if (b_done) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_done_unexpected actual=1 required=0");
                end else begin
                    e = exp_b.pop_front();
                    check("b_err_resp", {b_err, b_ena, 32'(cyc)}, {1'b1, 1'b0, 32'(e)});
                end
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
        int n;
        n = 0;
        @(negedge clk);
        while (!if_a.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout actual=busy required=ready");
        end
        if_a.req_store  = st;
        if_a.req_funct3 = f3;
        if_a.req_addr   = addr;
        if_a.req_wdata  = wd;
        if_a.req_rd     = rd;
        if_a.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        if_a.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_resp.size() != 0 || !if_a.req_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=pending%0d required=0", exp_resp.size());
        end
    endtask

    initial begin : main
        int n;
        arst = 1'b1;
        if_a.req_valid = 1'b0; if_a.req_store = 1'b0; if_a.req_funct3 = '0;
        if_a.req_addr  = '0;   if_a.req_wdata = '0;   if_a.req_rd     = '0;
        if_b.req_valid = 1'b0; if_b.req_store = 1'b0; if_b.req_funct3 = '0;
        if_b.req_addr  = '0;   if_b.req_wdata = '0;   if_b.req_rd     = '0;
        if_b.bus_gnt   = 1'b0; if_b.bus_rvalid = 1'b0; if_b.bus_rdata  = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #1;
        check("rst_a_ctrl", {if_a.req_ready, if_a.bus_req, if_a.bus_we, a_done, a_err, a_ena},
              64'b100000);
        check("rst_a_data", {if_a.bus_addr, if_a.bus_wdata} | {a_waddr, a_wdata}, 64'h0);
        check("rst_b_ctrl", {if_b.req_ready, if_b.bus_req, b_done, b_err}, 64'b1000);
        repeat (3) @(negedge clk);
        arst = 1'b0;

        mem[0] = 32'h8000_0000;
        issue(1'b0, 3'b000, 32'h103, 32'h0, 5'd5);           // LB
        exp_resp.push_back(mk(1'b0, 1'b0, 1'b1, 5'd5, 32'hFFFF_FF80));
        wait_idle();
        issue(1'b0, 3'b100, 32'h103, 32'h0, 5'd6);           // LBU
        exp_resp.push_back(mk(1'b0, 1'b0, 1'b1, 5'd6, 32'h0000_0080));
        wait_idle();

        mem[0] = 32'h1122_3344;
        issue(1'b1, 3'b000, 32'h101, 32'hFFFF_FFAB, 5'd0);   // SB, upper wdata ignored
        exp_wr.push_back(mkw(32'h100, 32'h1122_AB44));
        exp_resp.push_back(mk(1'b1, 1'b0, 1'b0, 5'd0, 32'h0));
        wait_idle();

        mem[0] = 32'h1122_3344;
        mem[1] = 32'h5566_7788;
        issue(1'b1, 3'b010, 32'h102, 32'hDEAD_BEEF, 5'd0);   // SW crossing
        exp_wr.push_back(mkw(32'h100, 32'hBEEF_3344));
        exp_wr.push_back(mkw(32'h104, 32'h5566_DEAD));
        exp_resp.push_back(mk(1'b1, 1'b0, 1'b0, 5'd0, 32'h0));
        wait_idle();

        issue(1'b0, 3'b010, 32'h102, 32'h0, 5'd7);           // LW crossing
        exp_resp.push_back(mk(1'b0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF));
        wait_idle();
        issue(1'b0, 3'b001, 32'h103, 32'h0, 5'd8);           // LH crossing, negative
        exp_resp.push_back(mk(1'b0, 1'b0, 1'b1, 5'd8, 32'hFFFF_ADBE));
        wait_idle();
        issue(1'b0, 3'b101, 32'h106, 32'h0, 5'd9);           // LHU upper half
        exp_resp.push_back(mk(1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_5566));
        wait_idle();

        mem[2] = 32'hA5A5_A5A5;
        issue(1'b1, 3'b001, 32'h107, 32'hFFFF_1234, 5'd0);   // SH crossing
        exp_wr.push_back(mkw(32'h104, 32'h3466_DEAD));
        exp_wr.push_back(mkw(32'h108, 32'hA5A5_A512));
        exp_resp.push_back(mk(1'b1, 1'b0, 1'b0, 5'd0, 32'h0));
        wait_idle();

        issue(1'b1, 3'b010, 32'h10C, 32'hCAFE_BABE, 5'd0);   // aligned SW, no read
        exp_wr.push_back(mkw(32'h10C, 32'hCAFE_BABE));
        exp_resp.push_back(mk(1'b1, 1'b0, 1'b0, 5'd0, 32'h0));
        wait_idle();

        issue(1'b0, 3'b010, 32'h10C, 32'h0, 5'd0);           // LW to x0
        exp_resp.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
        wait_idle();
        issue(1'b0, 3'b111, 32'h100, 32'h0, 5'd3);           // illegal load code
        exp_resp.push_back(mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h0));
        wait_idle();
        issue(1'b0, 3'b011, 32'h100, 32'h0, 5'd4);           // LD is illegal at XLEN=32
        exp_resp.push_back(mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h0));
        wait_idle();
        issue(1'b1, 3'b100, 32'h100, 32'h1, 5'd0);           // illegal store code
        exp_resp.push_back(mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h0));
        wait_idle();

        // Abort a read after its grant; the stale rvalid lands during the next op's RD0.
        mem[4] = 32'hCAFE_F00D;
        issue(1'b0, 3'b010, 32'h110, 32'h0, 5'd10);
        n = 0;
        while (!(if_a.bus_gnt && !if_a.bus_we) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL abort_gnt_timeout actual=nognt required=gnt");
        end
        @(posedge clk);
        #2;
        arst = 1'b1;
        #1;
        check("arst_async_ctrl",
              {if_a.req_ready, if_a.bus_req, if_a.bus_we, a_done, a_err, a_ena}, 64'b100000);
        check("arst_async_bus", {if_a.bus_addr, if_a.bus_wdata}, 64'h0);
        @(negedge clk);
        arst = 1'b0;
        issue(1'b0, 3'b100, 32'h103, 32'h0, 5'd11);          // LBU after abort
        exp_resp.push_back(mk(1'b0, 1'b0, 1'b1, 5'd11, 32'h0000_00BE));
        wait_idle();

        // No-split instance: crossing SW errors the cycle after accept.
        @(posedge clk);
        #1;
        if_b.req_store  = 1'b1;
        if_b.req_funct3 = 3'b010;
        if_b.req_addr   = 32'h102;
        if_b.req_wdata  = 32'hDEAD_BEEF;
        if_b.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        if_b.req_valid = 1'b0;
        exp_b.push_back(cyc);
        repeat (6) @(negedge clk);

        check("read_grants", 64'(rd_gnts), 64'd15);
        check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        check("b_queue_drained", 64'(exp_b.size()), 64'd0);
        check("b_bus_req_never", 64'(b_req_seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
